// File: rtl/fifo_rd_packer_if.sv
// Read-side packer bus: FIFO read port, flush request and the packed-word stream.
interface fifo_rd_packer_if #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4
);
  logic                           empty;
  logic [DATA_W-1:0]              rd_data;
  logic                           ren;
  logic                           flush;
  logic [DATA_W*WORD_BYTES-1:0]   m_data;
  logic [WORD_BYTES-1:0]          m_keep;
  logic                           m_valid;
  logic                           m_ready;
  logic                           busy;

  // Packer side
  modport master (
    input  empty, rd_data, flush, m_ready,
    output ren, m_data, m_keep, m_valid, busy
  );

  // FIFO / downstream / control side
  modport slave (
    output empty, rd_data, flush, m_ready,
    input  ren, m_data, m_keep, m_valid, busy
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Drains bytes from the FIFO read port and packs WORD_BYTES of them (first byte in
// the LSBs) into one word on a valid/ready stream; flush emits a partial word.
module fifo_rd_packer #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                rclk,
  input  logic                rst,
  fifo_rd_packer_if.master    bus
);
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam int LW = $clog2(WORD_BYTES);
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int SW = CW + IW;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                           state;
  logic [CW-1:0]                        cnt;
  logic [LW-1:0]                        lane;
  logic [RD_LAT-1:0]                    vld_pipe;
  logic [IW-1:0]                        inflight;
  logic [SW-1:0]                        occ;
  logic                                 ret;
  logic                                 ren;
  logic                                 flush_pend;
  logic                                 flush_word;
  logic                                 valid_q;
  logic [WORD_BYTES-1:0][DATA_W-1:0]    data_q;
  logic [WORD_BYTES-1:0]                keep_q;
  logic [WORD_BYTES-1:0]                keep_part;

  assign ret  = vld_pipe[RD_LAT-1];
  assign lane = cnt[LW-1:0];
  assign occ  = SW'(cnt) + SW'(inflight);

  // Reads in flight = issued reads still walking the latency pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(vld_pipe[i]);
  end

  // Partial-word mask: one bit per captured byte
  always_comb begin
    keep_part = '0;
    for (int i = 0; i < WORD_BYTES; i++) keep_part[i] = (CW'(i) < cnt);
  end

  // Issue a read only while the word (captured + in flight) still has room;
  // gated by rst so nothing is read while reset is held
  always_comb begin
    ren = rst && (state == FILL) && !bus.empty && !flush_pend &&
          (occ < SW'(WORD_BYTES));
  end

  // Latency pipe tracking accepted reads until their byte returns
  always_ff @(posedge rclk) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= ren;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Word assembly, hold/handshake and flush sequencing
  always_ff @(posedge rclk) begin
    if (!rst) begin
      state      <= FILL;
      cnt        <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
      flush_pend <= 1'b0;
      flush_word <= 1'b0;
    end else begin
      // A flush is always latched; it only takes effect in FILL once reads drain
      if (bus.flush) flush_pend <= 1'b1;
      case (state)
        FILL: begin
          if (ret) begin
            data_q[lane] <= bus.rd_data;
            cnt          <= cnt + CW'(1);
            if (cnt == CW'(WORD_BYTES - 1)) begin
              state      <= HOLD;
              valid_q    <= 1'b1;
              keep_q     <= '1;
              flush_word <= 1'b0;
            end
          end else if (flush_pend && (inflight == '0)) begin
            if (cnt != '0) begin
              // Unused lanes are already zero from the previous accept/reset
              state      <= HOLD;
              valid_q    <= 1'b1;
              keep_q     <= keep_part;
              flush_word <= 1'b1;
            end else if (!bus.flush) begin
              flush_pend <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            state      <= FILL;
            valid_q    <= 1'b0;
            cnt        <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            flush_word <= 1'b0;
            if (flush_word && !bus.flush) flush_pend <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.ren     = ren;
  assign bus.m_data  = data_q;
  assign bus.m_keep  = keep_q;
  assign bus.m_valid = valid_q;
  assign bus.busy    = valid_q || (cnt != '0) || (inflight != '0) || flush_pend;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO byte queue model feeding the read port,
// collected output words compared against hand-computed values.
module tb_fifo_rd_packer;
  logic rclk;
  logic rst;

  fifo_rd_packer_if #(.DATA_W(8), .WORD_BYTES(4)) bus ();

  fifo_rd_packer #(.DATA_W(8), .WORD_BYTES(4), .RD_LAT(1)) dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int          checks;
  int          errors;
  logic [7:0]  fifo_q[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        gate;
  logic        ren_s;
  logic        mv_s;
  logic [31:0] w;
  logic [3:0]  k;

  task automatic refresh_empty();
    bus.empty = (fifo_q.size() == 0) || gate;
  endtask

  task automatic load_word(input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(wd[8*i +: 8]);
    refresh_empty();
  endtask

  // One cycle: sample mid-cycle, advance past the edge, then update the FIFO model
  task automatic tick();
    logic acc;
    #1;
    ren_s = bus.ren;
    mv_s  = bus.m_valid;
    acc   = bus.ren && !bus.empty;
    checks++;
    if (bus.ren && bus.empty) begin
      errors++;
      $display("FAIL ren_while_empty ren=%0b empty=%0b required ren=0", bus.ren, bus.empty);
    end
    if (bus.m_valid && bus.m_ready) begin
      got_data.push_back(bus.m_data);
      got_keep.push_back(bus.m_keep);
    end
    @(posedge rclk);
    #1;
    if (acc) bus.rd_data = fifo_q.pop_front();
    refresh_empty();
  endtask

  task automatic first_word();
    w = (got_data.size() > 0) ? got_data[0] : 'x;
    k = (got_keep.size() > 0) ? got_keep[0] : 'x;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.empty = 1'b0; bus.m_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge rclk); #1;
      checks += 4;
      if (bus.ren !== 1'b0)     begin errors++; $display("FAIL reset_ren got=%b exp=0", bus.ren); end
      if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
      if (bus.m_keep !== 4'h0)  begin errors++; $display("FAIL reset_m_keep got=%h exp=0", bus.m_keep); end
      if (bus.busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    end
    refresh_empty();
    rst = 1'b1;
    @(posedge rclk); #1;
  endtask

  task automatic test_basic();
    int ren_n, first, last, mv_n, mv_first;
    got_data.delete(); got_keep.delete();
    ren_n = 0; first = -1; last = -1; mv_n = 0; mv_first = -1;
    bus.m_ready = 1'b1;
    load_word(32'h44332211, 4);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ren_s) begin ren_n++; if (first < 0) first = i; last = i; end
      if (mv_s)  begin mv_n++; if (mv_first < 0) mv_first = i; end
    end
    first_word();
    checks += 6;
    if (ren_n !== 4)          begin errors++; $display("FAIL basic_ren_count got=%0d exp=4", ren_n); end
    if (last - first !== 3)   begin errors++; $display("FAIL basic_ren_span got=%0d exp=3", last - first); end
    if (mv_n !== 1)           begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", mv_n); end
    // read accepted at the edge ending cycle `last`, byte captured one edge later,
    // so m_valid is first seen two sample points after the last ren
    if (mv_first !== last + 2) begin errors++; $display("FAIL basic_valid_latency got=%0d exp=%0d", mv_first, last + 2); end
    if (w !== 32'h44332211)   begin errors++; $display("FAIL basic_data got=%h exp=44332211", w); end
    if (k !== 4'hF)           begin errors++; $display("FAIL basic_keep got=%h exp=f", k); end
  endtask

  task automatic test_backpressure();
    got_data.delete(); got_keep.delete();
    bus.m_ready = 1'b0;
    load_word(32'h44332211, 4);
    load_word(32'h88776655, 4);
    for (int i = 0; i < 20 && !bus.m_valid; i++) tick();
    checks++;
    if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b exp=1", bus.m_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 2;
      if (bus.m_data !== 32'h44332211) begin errors++; $display("FAIL bp_stall_data got=%h exp=44332211", bus.m_data); end
      if (ren_s !== 1'b0)              begin errors++; $display("FAIL bp_stall_ren got=%b exp=0", ren_s); end
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 30 && got_data.size() < 2; i++) tick();
    checks += 3;
    if (got_data.size() !== 2) begin errors++; $display("FAIL bp_word_count got=%0d exp=2", got_data.size()); end
    first_word();
    if (w !== 32'h44332211)    begin errors++; $display("FAIL bp_word0 got=%h exp=44332211", w); end
    w = (got_data.size() > 1) ? got_data[1] : 'x;
    if (w !== 32'h88776655)    begin errors++; $display("FAIL bp_word1 got=%h exp=88776655", w); end
  endtask

  task automatic test_gaps();
    got_data.delete(); got_keep.delete();
    bus.m_ready = 1'b1;
    load_word(32'hA4A3A2A1, 4);
    for (int i = 0; i < 60 && got_data.size() < 1; i++) begin
      gate = ((i / 2) % 2) == 1;
      refresh_empty();
      tick();
    end
    gate = 1'b0;
    refresh_empty();
    first_word();
    checks += 2;
    if (w !== 32'hA4A3A2A1) begin errors++; $display("FAIL gaps_data got=%h exp=a4a3a2a1", w); end
    if (k !== 4'hF)         begin errors++; $display("FAIL gaps_keep got=%h exp=f", k); end
  endtask

  task automatic test_flush();
    int n0;
    got_data.delete(); got_keep.delete();
    bus.m_ready = 1'b1;
    load_word(32'h0000BBAA, 2);
    repeat (5) tick();
    checks += 2;
    if (got_data.size() !== 0) begin errors++; $display("FAIL flush_early_word got=%0d exp=0", got_data.size()); end
    if (bus.busy !== 1'b1)     begin errors++; $display("FAIL flush_busy_partial got=%b exp=1", bus.busy); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    for (int i = 0; i < 10 && got_data.size() < 1; i++) tick();
    repeat (2) tick();
    first_word();
    checks += 3;
    if (w !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got=%h exp=0000bbaa", w); end
    if (k !== 4'b0011)      begin errors++; $display("FAIL flush_keep got=%b exp=0011", k); end
    if (bus.busy !== 1'b0)  begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", bus.busy); end

    // flush with nothing captured: latched, then cleared without a word
    n0 = got_data.size();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_empty_pend got=%b exp=1", bus.busy); end
    repeat (3) tick();
    checks += 2;
    if (got_data.size() !== n0) begin errors++; $display("FAIL flush_empty_word got=%0d exp=%0d", got_data.size(), n0); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL flush_empty_clear got=%b exp=0", bus.busy); end

    // flush coinciding with the last byte: full word, then nothing more
    got_data.delete(); got_keep.delete();
    load_word(32'h04030201, 4);
    repeat (4) tick();
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    repeat (8) tick();
    first_word();
    checks += 4;
    if (got_data.size() !== 1) begin errors++; $display("FAIL flush_last_count got=%0d exp=1", got_data.size()); end
    if (w !== 32'h04030201)    begin errors++; $display("FAIL flush_last_data got=%h exp=04030201", w); end
    if (k !== 4'hF)            begin errors++; $display("FAIL flush_last_keep got=%h exp=f", k); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL flush_last_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    got_data.delete(); got_keep.delete();
    bus.m_ready = 1'b1;
    load_word(32'h54535251, 4);
    repeat (4) tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b0;
    fifo_q.delete();
    refresh_empty();
    repeat (2) tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_reset got=%b exp=0", bus.busy); end
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (got_data.size() !== 0) begin errors++; $display("FAIL rmid_no_word got=%0d exp=0", got_data.size()); end
    load_word(32'h64636261, 4);
    for (int i = 0; i < 20 && got_data.size() < 1; i++) tick();
    repeat (2) tick();
    first_word();
    checks += 3;
    if (got_data.size() !== 1) begin errors++; $display("FAIL rmid_count got=%0d exp=1", got_data.size()); end
    if (w !== 32'h64636261)    begin errors++; $display("FAIL rmid_data got=%h exp=64636261", w); end
    if (k !== 4'hF)            begin errors++; $display("FAIL rmid_keep got=%h exp=f", k); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; gate = 1'b0;
    rst = 1'b0;
    bus.empty = 1'b1; bus.rd_data = '0; bus.flush = 1'b0; bus.m_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
